// File: rtl/tile_rd_if.sv
// tile_rd_if: AXI read-address and read-data handshake bundle for the tile fetcher
interface tile_rd_if #(parameter int AW = 32);
  logic arvalid, arready, rvalid, rlast;
  logic [AW-1:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  modport master(output arvalid, araddr, arlen, arsize, arburst, input arready, rvalid, rlast);
  modport slave(input arvalid, araddr, arlen, arsize, arburst, output arready, rvalid, rlast);
endinterface

// File: rtl/tile_rd_addr_gen.sv
// tile_rd_addr_gen: walks the input map block by block issuing one INCR burst per tile row per channel
module tile_rd_addr_gen #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int KSIZE = 3,
  parameter int POX = 15,
  parameter int POY = 3,
  parameter int STRIDE = 2,
  parameter int IW = 224,
  parameter int IH = 224,
  parameter int CH = 4,
  parameter int BURST = 16,
  parameter int MAXOUT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          init_addr_en,
  input  logic [AW-1:0] init_addr,
  input  logic          abort,
  input  logic          result_valid,
  tile_rd_if.master     axi,
  output logic          blkend,
  output logic          mapend,
  output logic          busy
);
  localparam int EB = DW / 8;
  localparam int TR = (POY - 1) * STRIDE + KSIZE;
  localparam int RPB = POY * STRIDE;
  localparam int NBX = IW / (POX * STRIDE);
  localparam int NBY = IH / RPB;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, WAIT_RES} state_t;
  state_t state, state_n;
  logic [AW-1:0] base, base_n;
  logic [15:0] bx, by, c, r, bx_n, by_n, c_n, r_n, out_cnt, cnt_n, rlim;
  logic [31:0] rem;
  logic arv, arv_n, res_seen, res_n, abt, abt_n, acc, ret, stop, last_r, last_c, last_blk;
  assign acc = arv & axi.arready;
  assign ret = axi.rvalid & axi.rlast & (out_cnt != 16'd0);
  assign cnt_n = out_cnt + 16'(acc) - 16'(ret);
  assign stop = abort | abt;
  // rows past the bottom edge of the map are clipped from the last block row
  assign rem = 32'(IH) - 32'(by) * 32'(RPB);
  assign rlim = (rem < 32'(TR)) ? rem[15:0] : 16'(TR);
  assign last_r = r == rlim - 16'd1;
  assign last_c = c == 16'(CH - 1);
  assign last_blk = (bx == 16'(NBX - 1)) && (by == 16'(NBY - 1));
  assign busy = state != IDLE;
  assign axi.arvalid = arv;
  assign axi.araddr = base + AW'(c) * AW'(IW * IH * EB) + (AW'(by) * AW'(RPB) + AW'(r)) * AW'(IW * EB)
                    + AW'(bx) * AW'(POX * STRIDE * EB);
  assign axi.arlen = 8'(BURST - 1);
  assign axi.arsize = 3'($clog2(EB));
  assign axi.arburst = 2'b01;
  // next-state, walk counters and the held AR valid
  always_comb begin
    state_n = state;
    arv_n = arv;
    base_n = base;
    {bx_n, by_n, c_n, r_n} = {bx, by, c, r};
    res_n = res_seen;
    abt_n = stop;
    blkend = 1'b0;
    mapend = 1'b0;
    case (state)
      IDLE: begin
        abt_n = 1'b0;
        res_n = 1'b0;
        if (init_addr_en) begin
          base_n = init_addr;
          {bx_n, by_n, c_n, r_n} = '0;
          arv_n = 1'b1;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        res_n = res_seen | result_valid;
        if (acc) begin
          r_n = last_r ? 16'd0 : r + 16'd1;
          c_n = last_r ? (last_c ? 16'd0 : c + 16'd1) : c;
        end
        if (acc && last_r && last_c) begin
          arv_n = 1'b0;
          state_n = DRAIN;
        end else if (stop) begin
          arv_n = arv & ~acc;
          state_n = (arv & ~acc) ? ISSUE : DRAIN;
        end else arv_n = cnt_n < 16'(MAXOUT);
      end
      DRAIN: begin
        res_n = res_seen | result_valid;
        if (out_cnt == 16'd0) begin
          blkend = ~stop;
          mapend = ~stop & last_blk;
          state_n = (stop | last_blk) ? IDLE : WAIT_RES;
        end
      end
      WAIT_RES: begin
        if (stop) state_n = DRAIN;
        else if (res_seen | result_valid) begin
          res_n = 1'b0;
          bx_n = (bx == 16'(NBX - 1)) ? 16'd0 : bx + 16'd1;
          by_n = (bx == 16'(NBX - 1)) ? by + 16'd1 : by;
          c_n = 16'd0;
          r_n = 16'd0;
          arv_n = 1'b1;
          state_n = ISSUE;
        end
      end
      default: ;
    endcase
  end
  // state and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      arv <= 1'b0;
      base <= '0;
      {bx, by, c, r} <= '0;
      out_cnt <= '0;
      res_seen <= 1'b0;
      abt <= 1'b0;
    end else begin
      state <= state_n;
      arv <= arv_n;
      base <= base_n;
      {bx, by, c, r} <= {bx_n, by_n, c_n, r_n};
      out_cnt <= cnt_n;
      res_seen <= res_n;
      abt <= abt_n;
    end
  end
endmodule

// File: tb/tb_tile_rd_addr_gen.sv
// tb_tile_rd_addr_gen: scoreboard bench for the tile read-address generator
module tb_tile_rd_addr_gen;
  localparam int BURST = 16;
  logic clk = 1'b0, rst_n = 1'b1;
  logic init_en = 1'b0, abort_r = 1'b0, resv = 1'b0, ardy = 1'b0, rv = 1'b0, rl = 1'b0, sel = 1'b0;
  logic [31:0] init_a = '0;
  logic blk0, map0, busy0, blk1, map1, busy1;
  logic arv, blkend, mapend, busy;
  logic [31:0] araddr;
  int checks = 0, errors = 0, cyc = 0, acc_cnt = 0, rl_cnt = 0, rl_pend = 0;
  logic auto_rl = 1'b0;
  int rq[$];
  logic [31:0] exp_q[$];
  logic s_arv, s_acc, s_blk, s_map, s_busy;
  logic [31:0] s_addr;
  tile_rd_if #(.AW(32)) i0 ();
  tile_rd_if #(.AW(32)) i1 ();
  assign i0.arready = ardy & ~sel;
  assign i0.rvalid = rv & ~sel;
  assign i0.rlast = rl;
  assign i1.arready = ardy & sel;
  assign i1.rvalid = rv & sel;
  assign i1.rlast = rl;
  assign arv = sel ? i1.arvalid : i0.arvalid;
  assign araddr = sel ? i1.araddr : i0.araddr;
  assign blkend = sel ? blk1 : blk0;
  assign mapend = sel ? map1 : map0;
  assign busy = sel ? busy1 : busy0;
  tile_rd_addr_gen dut0 (
    .clk(clk), .rst_n(rst_n), .init_addr_en(init_en & ~sel), .init_addr(init_a),
    .abort(abort_r & ~sel), .result_valid(resv & ~sel), .axi(i0),
    .blkend(blk0), .mapend(map0), .busy(busy0));
  tile_rd_addr_gen #(.IW(8), .IH(8), .POX(1), .POY(1), .STRIDE(2), .KSIZE(3), .CH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .init_addr_en(init_en & sel), .init_addr(init_a),
    .abort(abort_r & sel), .result_valid(resv & sel), .axi(i1),
    .blkend(blk1), .mapend(map1), .busy(busy1));
  always #5 clk = ~clk;
  // one clock: sample outputs mid-cycle, then drive the R channel just after the edge
  task automatic step();
    @(negedge clk);
    s_arv = arv;
    s_addr = araddr;
    s_acc = arv & ardy;
    s_blk = blkend;
    s_map = mapend;
    s_busy = busy;
    if (s_acc) begin
      acc_cnt++;
      if (auto_rl) rq.push_back(cyc + BURST);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rl_pend > 0 || (rq.size() > 0 && rq[0] <= cyc)) begin
      if (rl_pend > 0) rl_pend--;
      else void'(rq.pop_front());
      rv = 1'b1;
      rl = 1'b1;
      rl_cnt++;
    end else begin
      rv = 1'b0;
      rl = 1'b0;
    end
  endtask
  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(negedge clk);
    checks++; if (i0.arvalid !== 1'b0) begin errors++; $display("FAIL reset_arvalid got %0d expected 0", i0.arvalid); end
    checks++; if (i0.araddr !== 32'd0) begin errors++; $display("FAIL reset_araddr got %0d expected 0", i0.araddr); end
    checks++; if (blk0 !== 1'b0) begin errors++; $display("FAIL reset_blkend got %0d expected 0", blk0); end
    checks++; if (map0 !== 1'b0) begin errors++; $display("FAIL reset_mapend got %0d expected 0", map0); end
    checks++; if (busy0 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d/%0d expected 0", busy0, busy1); end
    checks++; if (i0.arlen !== 8'd15) begin errors++; $display("FAIL arlen got %0d expected 15", i0.arlen); end
    checks++; if (i0.arsize !== 3'd2) begin errors++; $display("FAIL arsize got %0d expected 2", i0.arsize); end
    checks++; if (i0.arburst !== 2'b01) begin errors++; $display("FAIL arburst got %0d expected 1", i0.arburst); end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic test_block();
    int n = 0, blks = 0, st = 0, mx = 0, t_blk = 0, gap = -1, o;
    logic chk6 = 1'b0, rsd = 1'b0;
    logic [31:0] e;
    sel = 1'b0; auto_rl = 1'b1; ardy = 1'b1; init_a = '0; acc_cnt = 0; rl_cnt = 0;
    for (int c = 0; c < 4; c++) for (int r = 0; r < 7; r++) exp_q.push_back(32'(c * 200704 + r * 896));
    init_en = 1'b1; step(); init_en = 1'b0;
    for (int t = 0; t < 3000 && gap < 0; t++) begin
      step();
      if (s_acc) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL araddr unexpected burst got %0d", s_addr); end
        else begin
          e = exp_q.pop_front();
          if (s_addr !== e) begin errors++; $display("FAIL araddr got %0d expected %0d", s_addr, e); end
        end
        n++;
        if (blks == 1) gap = cyc - t_blk;
      end
      if (chk6) begin
        checks++; if (s_acc !== 1'b1) begin errors++; $display("FAIL stall_accept got %0d expected 1", s_acc); end
        chk6 = 1'b0;
      end
      if (st > 0) begin
        checks++;
        if (s_arv !== 1'b1 || s_addr !== 32'd1792) begin errors++; $display("FAIL stall_hold got arvalid %0d araddr %0d expected 1 1792", s_arv, s_addr); end
        st--;
        if (st == 0) begin ardy = 1'b1; chk6 = 1'b1; end
      end else if (s_acc && n == 2) begin
        ardy = 1'b0; st = 5;
      end
      o = acc_cnt - rl_cnt + int'(rl);
      if (o > mx) mx = o;
      resv = (n == 28 && !rsd);
      if (resv) rsd = 1'b1;
      if (s_blk) begin
        blks++; t_blk = cyc;
        checks++; if (rl_cnt !== 28) begin errors++; $display("FAIL blkend_rlasts got %0d expected 28", rl_cnt); end
        checks++; if (exp_q.size() !== 0 || s_map !== 1'b0) begin errors++; $display("FAIL blkend_state got left %0d mapend %0d expected 0 0", exp_q.size(), s_map); end
        for (int c = 0; c < 4; c++) for (int r = 0; r < 7; r++) exp_q.push_back(32'(120 + c * 200704 + r * 896));
      end
    end
    checks++; if (gap !== 2) begin errors++; $display("FAIL early_result_gap got %0d expected 2", gap); end
    checks++; if (blks !== 1) begin errors++; $display("FAIL block_blkends got %0d expected 1", blks); end
    checks++; if (mx !== 4) begin errors++; $display("FAIL max_outstanding got %0d expected 4", mx); end
  endtask
  task automatic test_back_to_back();
    int blks = 0, a;
    logic [31:0] e;
    acc_cnt = 0; rl_cnt = 0;
    for (int t = 0; t < 2000 && blks == 0; t++) begin
      step();
      if (s_acc) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL araddr unexpected burst got %0d", s_addr); end
        else begin
          e = exp_q.pop_front();
          if (s_addr !== e) begin errors++; $display("FAIL araddr got %0d expected %0d", s_addr, e); end
        end
      end
      if (s_blk) blks++;
    end
    checks++; if (blks !== 1) begin errors++; $display("FAIL b2b_blkend got %0d expected 1", blks); end
    checks++; if (acc_cnt !== 27 || exp_q.size() !== 0) begin errors++; $display("FAIL b2b_count got %0d left %0d expected 27 0", acc_cnt, exp_q.size()); end
    checks++; if (rl_cnt !== 28) begin errors++; $display("FAIL b2b_rlasts got %0d expected 28", rl_cnt); end
    a = acc_cnt;
    repeat (10) step();
    checks++; if (acc_cnt !== a || s_busy !== 1'b1) begin errors++; $display("FAIL wait_result got accepts %0d busy %0d expected %0d 1", acc_cnt, s_busy, a); end
  endtask
  task automatic test_abort();
    int nb = 0;
    logic ab = 1'b0, fell = 1'b0;
    logic [31:0] e;
    auto_rl = 1'b0; acc_cnt = 0; rl_cnt = 0; ardy = 1'b1;
    exp_q.push_back(32'd240);
    exp_q.push_back(32'd1136);
    resv = 1'b1; step(); resv = 1'b0;
    repeat (20) begin
      step();
      if (s_acc) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL araddr unexpected burst got %0d", s_addr); end
        else begin
          e = exp_q.pop_front();
          if (s_addr !== e) begin errors++; $display("FAIL araddr got %0d expected %0d", s_addr, e); end
        end
      end
      if (s_blk) nb++;
      abort_r = (acc_cnt == 1 && !ab);
      if (abort_r) ab = 1'b1;
    end
    checks++; if (acc_cnt !== 2 || s_arv !== 1'b0) begin errors++; $display("FAIL abort_stop got accepts %0d arvalid %0d expected 2 0", acc_cnt, s_arv); end
    checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL abort_busy_held got %0d expected 1", s_busy); end
    rl_pend = 1;
    repeat (5) begin step(); if (s_blk) nb++; end
    checks++; if (s_busy !== 1'b1) begin errors++; $display("FAIL abort_one_rlast got busy %0d expected 1", s_busy); end
    rl_pend = 1;
    for (int t = 0; t < 10 && !fell; t++) begin
      step();
      if (s_blk) nb++;
      fell = !s_busy;
    end
    checks++; if (fell !== 1'b1) begin errors++; $display("FAIL abort_idle got busy %0d expected 0", s_busy); end
    checks++; if (nb !== 0 || acc_cnt !== 2) begin errors++; $display("FAIL abort_quiet got blkends %0d accepts %0d expected 0 2", nb, acc_cnt); end
  endtask
  task automatic test_maxout();
    logic fell = 1'b0;
    logic [31:0] e;
    auto_rl = 1'b0; acc_cnt = 0; rl_cnt = 0; ardy = 1'b1; init_a = 32'h1000;
    for (int r = 0; r < 5; r++) exp_q.push_back(32'(32'h1000 + r * 896));
    init_en = 1'b1; step(); init_en = 1'b0;
    for (int t = 0; t < 40; t++) begin
      step();
      if (s_acc) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL araddr unexpected burst got %0d", s_addr); end
        else begin
          e = exp_q.pop_front();
          if (s_addr !== e) begin errors++; $display("FAIL araddr got %0d expected %0d", s_addr, e); end
        end
      end
      init_en = (t == 8);
      init_a = (t == 8) ? 32'h8000 : 32'h1000;
      if (t == 19) begin
        checks++; if (acc_cnt !== 4 || s_arv !== 1'b0) begin errors++; $display("FAIL maxout_cap got accepts %0d arvalid %0d expected 4 0", acc_cnt, s_arv); end
        rl_pend = 1;
      end
    end
    checks++; if (acc_cnt !== 5 || s_arv !== 1'b0) begin errors++; $display("FAIL maxout_refill got accepts %0d arvalid %0d expected 5 0", acc_cnt, s_arv); end
    checks++; if (exp_q.size() !== 0) begin errors++; $display("FAIL maxout_left got %0d expected 0", exp_q.size()); end
    abort_r = 1'b1; step(); abort_r = 1'b0;
    rl_pend = 4;
    for (int t = 0; t < 30 && !fell; t++) begin step(); fell = !s_busy; end
    checks++; if (fell !== 1'b1) begin errors++; $display("FAIL maxout_cleanup got busy %0d expected 0", s_busy); end
  endtask
  task automatic test_map();
    int blks = 0, maps = 0, map_blk = 0;
    logic [31:0] e;
    sel = 1'b1; auto_rl = 1'b1; ardy = 1'b1; resv = 1'b1; init_a = '0; acc_cnt = 0; rl_cnt = 0;
    rq.delete();
    exp_q.delete();
    for (int by = 0; by < 4; by++) for (int bx = 0; bx < 4; bx++) for (int r = 0; r < 3; r++)
      if (by * 2 + r < 8) exp_q.push_back(32'((by * 2 + r) * 32 + bx * 8));
    init_en = 1'b1; step(); init_en = 1'b0;
    for (int t = 0; t < 4000 && maps == 0; t++) begin
      step();
      if (s_acc) begin
        checks++;
        if (exp_q.size() == 0) begin errors++; $display("FAIL araddr unexpected burst got %0d", s_addr); end
        else begin
          e = exp_q.pop_front();
          if (s_addr !== e) begin errors++; $display("FAIL araddr got %0d expected %0d", s_addr, e); end
        end
      end
      if (s_blk) blks++;
      if (s_map) begin maps++; map_blk = s_blk ? blks : -1; end
    end
    checks++; if (maps !== 1 || map_blk !== 16) begin errors++; $display("FAIL mapend got %0d at blkend %0d expected 1 at 16", maps, map_blk); end
    checks++; if (acc_cnt !== 44 || exp_q.size() !== 0) begin errors++; $display("FAIL map_bursts got %0d left %0d expected 44 0", acc_cnt, exp_q.size()); end
    step();
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL map_idle got busy %0d expected 0", s_busy); end
    resv = 1'b0;
  endtask
  initial begin
    test_reset();
    test_block();
    test_back_to_back();
    test_abort();
    test_maxout();
    test_map();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
